uart_pattern_gen: RTL and testbench
===================================

Name: uart_pattern_gen

Overview:
- Parametrised test-pattern source for the UART transmit path.
- Produces a one-cycle `start` pulse and a data word for each character.
- Paced by the transmitter's `tx_busy` handshake, with a programmable inter-character gap, rather than by a fixed baud-period count.
- Supports incrementing, decrementing, LFSR and constant patterns, and finite or endless bursts.
- Sits between the bring-up control logic and `uart_tx`.

Parameters:
DATA_W, 8, width of data/seed/pattern word
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (DATA_W bits)
GAP_W, 16, width of gap input
CNT_W, 16, width of burst_len and sent_cnt
ACK_TO, 64, max clocks to wait for tx_busy rise after start

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
enable  input  1  rising edge starts a burst; low requests stop
mode  input  2  0=inc, 1=dec, 2=LFSR, 3=constant
seed  input  DATA_W  first data word of a burst
burst_len  input  CNT_W  characters per burst; 0 = endless
gap  input  GAP_W  idle clocks between tx completion and next start
tx_busy  input  1  high while uart_tx shifts a character
start  output  1  one-cycle request to uart_tx
data  output  DATA_W  character; valid on start, held until next start
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at burst end (normal, abort or error)
err  output  1  sticky ack-timeout flag; cleared at next burst launch
sent_cnt  output  CNT_W  characters sent in current/last burst; saturates at all-ones

Behaviour:
- Reset values: start=0, data=0, busy=0, done=0, err=0, sent_cnt=0, FSM=IDLE, enable edge register=0.
- States: IDLE, LOAD, SEND, WAIT_ACK, WAIT_TX, GAP, FIN.
- IDLE: on enable rising edge (registered 0->1) go to LOAD.
- LOAD (1 clk):
  - Latch mode, burst_len and gap.
  - data<=seed; in mode 2, seed 0 loads 1.
  - Clear sent_cnt and err.
  - Go to SEND.
- SEND (1 clk):
  - start=1; sent_cnt increments (saturating).
  - Ack counter clears; go to WAIT_ACK.
- WAIT_ACK:
  - tx_busy=1 -> WAIT_TX.
  - Ack counter reaching ACK_TO without tx_busy -> err=1, go to FIN.
  - tx_busy already high in the SEND cycle counts as ack on the next clock.
- WAIT_TX:
  - On first cycle with tx_busy=0, advance data per mode:
    - inc: data+1 mod 2^DATA_W.
    - dec: data-1 mod 2^DATA_W.
    - LFSR: (data>>1) ^ (data[0] ? LFSR_TAPS : 0).
    - const: unchanged.
  - If burst_len!=0 and sent_cnt==burst_len, or enable=0: go to FIN.
  - Otherwise go to GAP with the gap counter cleared.
- GAP:
  - Count latched gap clocks, then go to SEND.
  - gap=0 skips GAP entirely: next start is 1 clk after tx_busy is sampled low.
  - Next start is exactly gap+1 clks after tx_busy is first sampled low.
- FIN (1 clk): done=1, go to IDLE. data and sent_cnt hold their values.
- Stop request: enable falling mid-burst never truncates a character; the burst ends after the current tx completes.
- Enable edge during a burst is ignored. Config inputs change only at LOAD.
- Endless mode: sent_cnt saturates while transmission continues.
- Async reset at any state returns all outputs to reset values immediately. No done pulse.

Optional Feature:
- Macro: PATGEN_CHECKSUM_EN.
- Defined:
  - Extra output `checksum [DATA_W-1:0]`, reset 0, cleared in LOAD.
  - XOR-accumulates each data value in its SEND cycle.
  - Valid and stable from the FIN cycle onward.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- mode=0, seed=8'hFE, burst_len=4, gap=0, tx model busy 10 clks after start -> data FE,FF,00,01 on four start pulses; done pulse; sent_cnt=4; busy falls with done.
- mode=2, seed=8'h01, burst_len=4 -> data 01,B8,5C,2E. mode=2 with seed=0 -> first data 01.
- mode=1, seed=8'h00, burst_len=3, gap=16 -> data 00,FF,FE; each start exactly 17 clks after tx_busy first sampled low.
- tx_busy tied 0, ACK_TO=64 -> single start; err=1 and done pulse on the 65th clk after start; sent_cnt=1. Next burst launch clears err.
- burst_len=0, mode=3, seed=8'h55; drop enable during the 5th character -> fifth tx completes; no 6th start; done pulse; sent_cnt=5; data=55 throughout.
- Assert rstn low mid-WAIT_TX -> all outputs 0 the same cycle. With PATGEN_CHECKSUM_EN defined, checksum of FE,FF,00,01 = 8'h00.

Source files
------------

// File: rtl/uart_pattern_gen.sv
// Test-pattern source for uart_tx: one start pulse and data word per character, paced by tx_busy.
// Optional XOR checksum output when PATGEN_CHECKSUM_EN is defined.
module uart_pattern_gen #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int                GAP_W     = 16,
  parameter int                CNT_W     = 16,
  parameter int                ACK_TO    = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [GAP_W-1:0]  gap,
  input  logic              tx_busy,
  output logic              start,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  sent_cnt
`ifdef PATGEN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int ACK_W = $clog2(ACK_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_TX, S_GAP, S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_en_d;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_len;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [ACK_W-1:0]   r_ack_cnt;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_sent_cnt;
  logic               r_err;
  logic               w_start;
  logic               w_done;
  logic               w_advance;
  logic               w_timeout;
  logic               w_last;
  logic [DATA_W-1:0]  w_lfsr;
  logic [DATA_W-1:0]  w_data_adv;
  logic [DATA_W-1:0]  w_seed_adj;

  // Galois LFSR step: shift right, fold the dropped LSB back in through the tap mask
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_lfsr
      if (gi == DATA_W - 1) begin : g_top
        assign w_lfsr[gi] = r_data[0] & LFSR_TAPS[gi];
      end else begin : g_mid
        assign w_lfsr[gi] = r_data[gi+1] ^ (r_data[0] & LFSR_TAPS[gi]);
      end
    end
  endgenerate

  // An all-zero LFSR state would lock up, so a zero seed starts at 1 instead
  assign w_seed_adj = (mode == 2'd2 && seed == '0) ? DATA_W'(1) : seed;
  assign w_last     = (r_len != '0 && r_sent_cnt == r_len) || !enable;

  always_comb begin
    w_data_adv = r_data;
    case (r_mode)
      2'd0:    w_data_adv = r_data + DATA_W'(1);
      2'd1:    w_data_adv = r_data - DATA_W'(1);
      2'd2:    w_data_adv = w_lfsr;
      default: w_data_adv = r_data;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_advance    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:     if (enable && !r_en_d) w_state_next = S_LOAD;
      S_LOAD:     w_state_next = S_SEND;
      S_SEND: begin
        w_start      = 1'b1;
        w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          w_state_next = S_WAIT_TX;
        end else if (r_ack_cnt == ACK_W'(ACK_TO - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = S_FIN;
        end
      end
      S_WAIT_TX: begin
        if (!tx_busy) begin
          w_advance = 1'b1;
          if (w_last)              w_state_next = S_FIN;
          else if (r_gap == '0)    w_state_next = S_SEND;
          else                     w_state_next = S_GAP;
        end
      end
      S_GAP:      if (r_gap_cnt == r_gap - GAP_W'(1)) w_state_next = S_SEND;
      S_FIN: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_en_d     <= 1'b0;
      r_mode     <= '0;
      r_len      <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_ack_cnt  <= '0;
      r_data     <= '0;
      r_sent_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en_d  <= enable;
      if (r_state == S_LOAD) begin
        r_mode     <= mode;
        r_len      <= burst_len;
        r_gap      <= gap;
        r_data     <= w_seed_adj;
        r_sent_cnt <= '0;
        r_err      <= 1'b0;
      end
      if (w_start) begin
        r_ack_cnt <= '0;
        if (r_sent_cnt != '1) r_sent_cnt <= r_sent_cnt + CNT_W'(1);
      end
      if (r_state == S_WAIT_ACK && !tx_busy && !w_timeout) r_ack_cnt <= r_ack_cnt + ACK_W'(1);
      if (w_timeout) r_err <= 1'b1;
      if (w_advance) begin
        r_data    <= w_data_adv;
        r_gap_cnt <= '0;
      end
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

`ifdef PATGEN_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_checksum <= '0;
    end else if (r_state == S_LOAD) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= r_checksum ^ r_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign start    = w_start;
  assign done     = w_done;
  assign busy     = (r_state != S_IDLE);
  assign data     = r_data;
  assign err      = r_err;
  assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Bench for uart_pattern_gen: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_uart_pattern_gen;

  localparam int TX_LEN = 10;
  localparam int ACK_TO = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  seed = '0;
  logic [15:0] burst_len = '0;
  logic [15:0] gap = '0;
  logic        tx_busy = 1'b0;
  logic        start;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sent_cnt;
`ifdef PATGEN_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  uart_pattern_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .mode      (mode),
    .seed      (seed),
    .burst_len (burst_len),
    .gap       (gap),
    .tx_busy   (tx_busy),
    .start     (start),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sent_cnt  (sent_cnt)
`ifdef PATGEN_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;

  // reference model state: event times are negedge indices
  bit          m_active = 1'b0;
  bit          m_err = 1'b0;
  bit          m_en_prev = 1'b0;
  int          m_load_at = -1;
  int          m_next_start = -1;
  int          m_done_at = -1;
  int          m_err_set_at = -1;
  int          m_err_clr_at = -1;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_csum = '0;
  int          m_cnt = 0;
  logic [1:0]  m_mode = '0;
  int          m_len = 0;
  int          m_gap = 0;
  bit          tx_mute = 1'b0;
  int          tx_cnt = 0;
  logic [7:0]  obs[$];
  int          start_at[$];
  int          done_k = 0;
  int          n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] next_word(input logic [1:0] md, input logic [7:0] d);
    case (md)
      2'd0:    return d + 8'd1;
      2'd1:    return d - 8'd1;
      2'd2:    return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
      default: return d;
    endcase
  endfunction

  // model + transmitter emulation + per-cycle compare
  always @(negedge clk) begin
    k++;
    if (!rstn) begin
      m_active = 0; m_err = 0; m_en_prev = 0;
      m_load_at = -1; m_next_start = -1; m_done_at = -1;
      m_err_set_at = -1; m_err_clr_at = -1;
      tx_busy = 0; tx_cnt = 0;
    end else begin
      if (k == m_load_at)    m_active = 1;
      if (k == m_err_clr_at) m_err = 0;
      if (k == m_err_set_at) m_err = 1;
      chk("start", 32'(start), 32'(k == m_next_start));
      chk("done",  32'(done),  32'(k == m_done_at));
      chk("busy",  32'(busy),  32'(m_active));
      chk("err",   32'(err),   32'(m_err));
      if (k == m_next_start) begin
        chk("data_at_start", 32'(data), 32'(m_data));
        chk("cnt_at_start", 32'(sent_cnt), 32'(m_cnt));
        $display("t=%0t start data=%02h sent_cnt=%0d", $time, data, sent_cnt);
        obs.push_back(data);
        start_at.push_back(k);
        m_csum = m_csum ^ m_data;
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (tx_mute) begin
          m_done_at    = k + ACK_TO + 1;
          m_err_set_at = k + ACK_TO + 1;
        end else begin
          tx_busy = 1;
          tx_cnt  = TX_LEN;
        end
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_busy = 0;
          m_data = next_word(m_mode, m_data);
          if ((m_len != 0 && m_cnt == m_len) || !enable) m_done_at = k + 1;
          else m_next_start = k + m_gap + 1;
        end
      end
      if (k == m_done_at) begin
        chk("data_at_done", 32'(data), 32'(m_data));
        chk("cnt_at_done", 32'(sent_cnt), 32'(m_cnt));
`ifdef PATGEN_CHECKSUM_EN
        chk("checksum_at_done", 32'(checksum), 32'(m_csum));
`endif
        $display("t=%0t done sent_cnt=%0d err=%0b", $time, sent_cnt, err);
        done_k = k;
        n_done++;
        m_active = 0;
      end else if (!m_active && m_load_at < k && enable && !m_en_prev) begin
        m_load_at    = k + 1;
        m_next_start = k + 2;
        m_err_clr_at = k + 2;
        m_mode = mode;
        m_len  = int'(burst_len);
        m_gap  = int'(gap);
        m_data = (mode == 2'd2 && seed == 8'h00) ? 8'h01 : seed;
        m_cnt  = 0;
        m_csum = '0;
      end
      m_en_prev = enable;
    end
  end

  task automatic launch(input logic [1:0] md, input logic [7:0] sd, input logic [15:0] len, input logic [15:0] gp);
    @(posedge clk); #2;
    obs.delete();
    start_at.delete();
    mode = md; seed = sd; burst_len = len; gap = gp;
    enable = 1;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int  n0;
    bit  seen;
    n0 = n_done;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(posedge clk);
      if (n_done > n0) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no done within %0d clocks", nm, lim);
    end
    #2;
  endtask

  task automatic release_enable();
    @(posedge clk); #2;
    enable = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_seq(input string nm, input int n, input logic [39:0] e);
    logic [7:0] ev;
    chk({nm, "_count"}, 32'(obs.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++) begin
      ev = e[39 - 8*i -: 8];
      chk(nm, 32'(obs[i]), 32'(ev));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_cnt", 32'(sent_cnt), 32'(0));
    rstn = 1;
    repeat (3) @(posedge clk);

    // incrementing with wrap, gap 0
    launch(2'd0, 8'hFE, 16'd4, 16'd0);
    wait_done("inc", 300);
    check_seq("inc_seq", 4, 40'hFE_FF_00_01_00);
    chk("inc_cnt", 32'(sent_cnt), 32'd4);
    if (start_at.size() >= 2) chk("inc_spacing", 32'(start_at[1] - start_at[0]), 32'd11);
`ifdef PATGEN_CHECKSUM_EN
    chk("inc_checksum", 32'(checksum), 32'h00);
`endif
    release_enable();

    // LFSR
    launch(2'd2, 8'h01, 16'd4, 16'd2);
    wait_done("lfsr", 300);
    check_seq("lfsr_seq", 4, 40'h01_B8_5C_2E_00);
    release_enable();

    launch(2'd2, 8'h00, 16'd1, 16'd0);
    wait_done("lfsr0", 100);
    check_seq("lfsr_seed0", 1, 40'h01_00_00_00_00);
    release_enable();

    // decrementing with gap 16
    launch(2'd1, 8'h00, 16'd3, 16'd16);
    wait_done("dec", 300);
    check_seq("dec_seq", 3, 40'h00_FF_FE_00_00);
    if (start_at.size() >= 3) begin
      chk("dec_spacing1", 32'(start_at[1] - start_at[0]), 32'd27);
      chk("dec_spacing2", 32'(start_at[2] - start_at[1]), 32'd27);
    end
    release_enable();

    // ack timeout: transmitter never answers
    tx_mute = 1;
    launch(2'd0, 8'h33, 16'd4, 16'd0);
    wait_done("timeout", 200);
    tx_mute = 0;
    chk("to_err", 32'(err), 32'd1);
    chk("to_cnt", 32'(sent_cnt), 32'd1);
    check_seq("to_seq", 1, 40'h33_00_00_00_00);
    if (start_at.size() >= 1) chk("to_latency", 32'(done_k - start_at[0]), 32'd65);
    release_enable();

    // endless constant, stop request during 5th character
    launch(2'd3, 8'h55, 16'd0, 16'd3);
    for (int i = 0; i < 500 && obs.size() < 5; i++) @(posedge clk);
    #2;
    chk("endless_err_cleared", 32'(err), 32'd0);
    enable = 0;
    wait_done("endless", 100);
    check_seq("const_seq", 5, 40'h55_55_55_55_55);
    chk("endless_cnt", 32'(sent_cnt), 32'd5);
    repeat (3) @(posedge clk);

    // async reset while waiting on tx completion
    launch(2'd0, 8'h10, 16'd0, 16'd0);
    for (int i = 0; i < 50 && obs.size() < 1; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    rstn = 0;
    enable = 0;
    #1;
    chk("arst_start", 32'(start), 32'(0));
    chk("arst_data", 32'(data), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_err", 32'(err), 32'(0));
    chk("arst_cnt", 32'(sent_cnt), 32'(0));
`ifdef PATGEN_CHECKSUM_EN
    chk("arst_checksum", 32'(checksum), 32'(0));
`endif
    repeat (3) @(posedge clk);
    #2;
    rstn = 1;
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
